serial_2wire_regaccess: RTL and testbench

//  Command sequencer directly upstream of the 2-wire serial controller: turns one register command
//  (device, register, read/write, length) into that controller's enable/write/word handshake.

---
 rtl/serial_2wire_regaccess.sv | 222 ++++++++++++++++++++++
 tb/tb_serial_2wire_regaccess.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_2wire_regaccess.sv
// serial_2wire_regaccess: register command sequencer feeding a 2-wire
// serial controller; buffers write bytes, streams reads, recovers on NAK.
module serial_2wire_regaccess #(
  parameter int BITS           = 8,
  parameter int MAX_LEN        = 16,
  parameter int LEN_BITS       = $clog2(MAX_LEN + 1),
  parameter int ERR_RST_CYCLES = 4
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_start,
  input  logic                in_read,
  input  logic [6:0]          in_dev_addr,
  input  logic [BITS-1:0]     in_reg_addr,
  input  logic [LEN_BITS-1:0] in_len,
  input  logic [BITS-1:0]     in_wr_data,
  input  logic                in_wr_valid,
  output logic                out_wr_ready,
  output logic [BITS-1:0]     out_rd_data,
  output logic                out_rd_valid,
  output logic                out_busy,
  output logic                out_done,
  output logic                out_err,
  output logic                out_ser_rst,
  output logic                out_ser_enable,
  output logic                out_ser_write,
  output logic [7:0]          out_ser_addr_write,
  output logic [7:0]          out_ser_addr_read,
  output logic [BITS-1:0]     out_ser_parallel,
  input  logic                in_ser_ready,
  input  logic                in_ser_err,
  input  logic                in_ser_next_word,
  input  logic                in_ser_word_finished,
  input  logic [BITS-1:0]     in_ser_parallel
);

  localparam int CW  = LEN_BITS + 1;
  localparam int IDX = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int RW  = $clog2(ERR_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, FINISH, ERR_RST, DONE
  } state_t;

  state_t              state;
  logic                read_q;
  logic [LEN_BITS-1:0] len_q;
  logic [BITS-1:0]     reg_q;
  logic [CW-1:0]       total;
  logic [CW-1:0]       nw_ctr;
  logic [CW-1:0]       wf_ctr;
  logic [LEN_BITS-1:0] wr_ptr;
  logic [RW-1:0]       rst_ctr;
  logic                rst_q;
  logic                nw_d;
  logic                wf_d;
  logic [BITS-1:0]     buffer [MAX_LEN];

  logic          nw_rise;
  logic          wf_rise;
  logic [CW-1:0] nw_next;
  logic [CW-1:0] wf_next;
  logic          buf_we;
  logic          err_hit;

  assign nw_rise = in_ser_next_word & ~nw_d;
  assign wf_rise = in_ser_word_finished & ~wf_d;
  assign nw_next = nw_ctr + CW'(1);
  assign wf_next = wf_ctr + CW'(1);
  assign buf_we  = (state == LOAD) & in_wr_valid
                 & out_wr_ready;
  assign err_hit = in_ser_err &
                   ((state == START) |
                    (state == RUN) |
                    (state == FINISH));

  // controller reset: error recovery pulse, forced while in reset
  assign out_ser_rst = rst_q | ~in_rst;

  // previous controller strobe levels for rising-edge detection
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      nw_d <= 1'b0;
      wf_d <= 1'b0;
    end else begin
      nw_d <= in_ser_next_word;
      wf_d <= in_ser_word_finished;
    end
  end

  // write byte buffer; contents only meaningful below wr_ptr
  always_ff @(posedge in_clk) begin
    if (buf_we) buffer[wr_ptr[IDX-1:0]] <= in_wr_data;
  end

  // command sequencer with registered outputs
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state              <= IDLE;
      read_q             <= 1'b0;
      len_q              <= '0;
      reg_q              <= '0;
      total              <= '0;
      nw_ctr             <= '0;
      wf_ctr             <= '0;
      wr_ptr             <= '0;
      rst_ctr            <= '0;
      rst_q              <= 1'b0;
      out_wr_ready       <= 1'b0;
      out_rd_data        <= '0;
      out_rd_valid       <= 1'b0;
      out_busy           <= 1'b0;
      out_done           <= 1'b0;
      out_err            <= 1'b0;
      out_ser_enable     <= 1'b0;
      out_ser_write      <= 1'b0;
      out_ser_addr_write <= '0;
      out_ser_addr_read  <= '0;
      out_ser_parallel   <= '0;
    end else begin
      out_done     <= 1'b0;
      out_rd_valid <= 1'b0;
      if (err_hit) begin
        state          <= ERR_RST;
        out_ser_enable <= 1'b0;
        rst_q          <= 1'b1;
        rst_ctr        <= '0;
        wr_ptr         <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_start) begin
              read_q   <= in_read;
              len_q    <= in_len;
              reg_q    <= in_reg_addr;
              total    <= CW'(in_len) + CW'(1);
              nw_ctr   <= '0;
              wf_ctr   <= '0;
              wr_ptr   <= '0;
              out_busy <= 1'b1;
              out_err  <= 1'b0;
              if (in_read && in_len == '0) begin
                state    <= DONE;
                out_done <= 1'b1;
                out_err  <= 1'b1;
              end else begin
                out_ser_addr_write <=
                  {in_dev_addr, 1'b0};
                out_ser_addr_read <=
                  {in_dev_addr, 1'b1};
                out_ser_write    <= ~in_read;
                out_ser_parallel <= in_reg_addr;
                if (!in_read && in_len != '0) begin
                  state        <= LOAD;
                  out_wr_ready <= 1'b1;
                end else begin
                  state <= START;
                end
              end
            end
          end
          LOAD: begin
            if (buf_we) begin
              wr_ptr <= wr_ptr + LEN_BITS'(1);
              if (wr_ptr + LEN_BITS'(1) == len_q) begin
                out_wr_ready <= 1'b0;
                state        <= START;
              end
            end
          end
          START: begin
            out_ser_parallel <= reg_q;
            out_ser_enable   <= 1'b1;
            if (!in_ser_ready) state <= RUN;
          end
          RUN: begin
            if (nw_rise) begin
              nw_ctr <= nw_next;
              if (nw_next == total)
                out_ser_enable <= 1'b0;
            end
            if (wf_rise) begin
              wf_ctr <= wf_next;
              if (!read_q && wf_next <= CW'(len_q))
                out_ser_parallel <=
                  buffer[wf_ctr[IDX-1:0]];
              if (read_q && wf_next >= CW'(2)) begin
                out_rd_data  <= in_ser_parallel;
                out_rd_valid <= 1'b1;
              end
            end
            if (wf_ctr == total) state <= FINISH;
          end
          FINISH: begin
            out_ser_enable <= 1'b0;
            if (in_ser_ready) begin
              state    <= DONE;
              out_done <= 1'b1;
              out_err  <= 1'b0;
            end
          end
          ERR_RST: begin
            if (rst_ctr == RW'(ERR_RST_CYCLES - 1)) begin
              rst_q    <= 1'b0;
              state    <= DONE;
              out_done <= 1'b1;
              out_err  <= 1'b1;
            end else begin
              rst_ctr <= rst_ctr + RW'(1);
            end
          end
          DONE: begin
            state    <= IDLE;
            out_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_2wire_regaccess.sv
// tb_serial_2wire_regaccess: directed commands against a behavioural
// 2-wire controller; scoreboard queues checked by monitor processes.
module tb_serial_2wire_regaccess;

  localparam int LB = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          rd;
  logic [6:0]    dev;
  logic [7:0]    regp;
  logic [LB-1:0] len;
  logic [7:0]    wdata;
  logic          wvalid;
  logic          wready;
  logic [7:0]    rdata;
  logic          rvalid;
  logic          busy;
  logic          done;
  logic          err;
  logic          ser_rst;
  logic          ser_en;
  logic          ser_wr;
  logic [7:0]    aw;
  logic [7:0]    ar;
  logic [7:0]    par_out;
  logic          ser_ready;
  logic          ser_err;
  logic          ser_nw;
  logic          ser_wf;
  logic [7:0]    par_in;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_rd[$];
  logic [7:0] exp_word[$];
  logic [7:0] exp_addr[$];
  logic [7:0] rd_bytes[$];
  bit         exp_err[$];
  bit         exp_go[$];
  bit         exp_wr[$];
  int         exp_rst[$];
  bit         nak_next = 0;
  bit         abort    = 0;
  bit         en_seen  = 0;
  int         rst_len  = 0;

  serial_2wire_regaccess dut (
    .in_clk               (clk),
    .in_rst               (rst_n),
    .in_start             (start),
    .in_read              (rd),
    .in_dev_addr          (dev),
    .in_reg_addr          (regp),
    .in_len               (len),
    .in_wr_data           (wdata),
    .in_wr_valid          (wvalid),
    .out_wr_ready         (wready),
    .out_rd_data          (rdata),
    .out_rd_valid         (rvalid),
    .out_busy             (busy),
    .out_done             (done),
    .out_err              (err),
    .out_ser_rst          (ser_rst),
    .out_ser_enable       (ser_en),
    .out_ser_write        (ser_wr),
    .out_ser_addr_write   (aw),
    .out_ser_addr_read    (ar),
    .out_ser_parallel     (par_out),
    .in_ser_ready         (ser_ready),
    .in_ser_err           (ser_err),
    .in_ser_next_word     (ser_nw),
    .in_ser_word_finished (ser_wf),
    .in_ser_parallel      (par_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic bad(string name, int val);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0d expected none", name, val);
  endtask

  // monitor: read bytes, done/err, controller reset pulse length
  always @(negedge clk) begin
    if (!rst_n) begin
      rst_len = 0;
    end else begin
      if (ser_en) en_seen = 1;
      if (rvalid) begin
        if (exp_rd.size() == 0) bad("rd_unexpected", rdata);
        else chk("rd_data", rdata, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_err.size() == 0) bad("done_unexpected", err);
        else chk("done_err", err, exp_err.pop_front());
      end
      if (ser_rst) begin
        rst_len++;
      end else if (rst_len > 0) begin
        if (exp_rst.size() == 0) bad("rst_unexpected", rst_len);
        else chk("rst_len", rst_len, exp_rst.pop_front());
        rst_len = 0;
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) begin
      @(negedge clk);
      if (ser_rst) abort = 1;
    end
  endtask

  // behavioural controller: one transaction per enable
  task automatic run_txn();
    int  w;
    bit  go;
    bit  wr;
    bit  stop;
    w = 0;
    go = 1;
    stop = 0;
    abort = 0;
    ser_ready = 0;
    wr = ser_wr;
    if (exp_addr.size() == 0) bad("addr_unexpected", aw);
    else chk("ser_addr", wr ? aw : ar, exp_addr.pop_front());
    if (exp_wr.size() == 0) bad("wr_unexpected", wr);
    else chk("ser_write", wr, exp_wr.pop_front());
    while (go && !stop) begin
      if (w == 0 || wr) begin
        if (exp_word.size() == 0) bad("word_unexpected", par_out);
        else chk("ser_word", par_out, exp_word.pop_front());
      end
      if (!wr && w > 0)
        par_in = (rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'hEE;
      wait_cyc(3);
      if (abort) break;
      if (nak_next) begin
        nak_next = 0;
        ser_err = 1;
        for (int i = 0; i < 100 && !ser_rst; i++) @(negedge clk);
        if (!ser_rst) bad("nak_rst_timeout", 100);
        ser_err = 0;
        stop = 1;
        break;
      end
      ser_nw = 1;
      wait_cyc(2);
      ser_nw = 0;
      if (abort) break;
      go = ser_en;
      if (exp_go.size() == 0) bad("go_unexpected", go);
      else chk("ack_continue", go, exp_go.pop_front());
      ser_wf = 1;
      wait_cyc(2);
      ser_wf = 0;
      if (abort) break;
      w++;
    end
    if (!abort && !stop) wait_cyc(3);
    ser_nw = 0;
    ser_wf = 0;
    ser_ready = 1;
  endtask

  initial begin
    ser_ready = 1;
    ser_err = 0;
    ser_nw = 0;
    ser_wf = 0;
    par_in = 0;
    forever begin
      @(negedge clk);
      if (ser_rst) begin
        ser_ready = 1;
        ser_err = 0;
        ser_nw = 0;
        ser_wf = 0;
      end else if (ser_en && ser_ready) begin
        run_txn();
      end
    end
  end

  task automatic cmd(bit r, logic [6:0] d, logic [7:0] ra, int l);
    @(negedge clk);
    start = 1;
    rd = r;
    dev = d;
    regp = ra;
    len = LB'(l);
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b[$], input int gap);
    int t;
    foreach (b[i]) begin
      repeat (gap) @(negedge clk);
      chk("en_in_load", ser_en, 0);
      wdata = b[i];
      wvalid = 1;
      t = 0;
      while (!wready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!wready) bad("wr_ready_timeout", t);
      @(negedge clk);
      wvalid = 0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (busy) bad("idle_timeout", t);
    @(negedge clk);
  endtask

  task automatic flush();
    exp_rd.delete();
    exp_word.delete();
    exp_addr.delete();
    rd_bytes.delete();
    exp_err.delete();
    exp_go.delete();
    exp_wr.delete();
    exp_rst.delete();
  endtask

  task automatic reset_state(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ser_rst"}, ser_rst, 1);
    chk({tag, "_enable"}, ser_en, 0);
    chk({tag, "_wr_ready"}, wready, 0);
    chk({tag, "_rd_valid"}, rvalid, 0);
    chk({tag, "_parallel"}, par_out, 0);
    chk({tag, "_addr_w"}, aw, 0);
    chk({tag, "_addr_r"}, ar, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] bytes[$];
    rst_n = 0;
    start = 0;
    rd = 0;
    dev = 0;
    regp = 0;
    len = 0;
    wdata = 0;
    wvalid = 0;
    repeat (3) @(negedge clk);
    reset_state("rst");
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("ser_rst_released", ser_rst, 0);

    // write dev 0x50 reg 0x10 {A5,3C}
    exp_addr.push_back(8'hA0);
    exp_wr.push_back(1);
    exp_word = '{8'h10, 8'hA5, 8'h3C};
    exp_go = '{1, 1, 0};
    exp_err.push_back(0);
    cmd(0, 7'h50, 8'h10, 2);
    bytes = '{8'hA5, 8'h3C};
    send(bytes, 0);
    wait_idle();

    // read dev 0x68 reg 0x75, slave returns 12,34
    exp_addr.push_back(8'hD1);
    exp_wr.push_back(0);
    exp_word.push_back(8'h75);
    exp_go = '{1, 1, 0};
    rd_bytes = '{8'h12, 8'h34};
    exp_rd = '{8'h12, 8'h34};
    exp_err.push_back(0);
    cmd(1, 7'h68, 8'h75, 2);
    wait_idle();

    // address NAK, then a clean write
    nak_next = 1;
    exp_addr.push_back(8'hA0);
    exp_wr.push_back(1);
    exp_word.push_back(8'h10);
    exp_rst.push_back(4);
    exp_err.push_back(1);
    cmd(0, 7'h50, 8'h10, 1);
    bytes = '{8'h55};
    send(bytes, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("err_held", err, 1);
    exp_addr.push_back(8'hA0);
    exp_wr.push_back(1);
    exp_word = '{8'h10, 8'h77};
    exp_go = '{1, 0};
    exp_err.push_back(0);
    cmd(0, 7'h50, 8'h10, 1);
    chk("err_cleared", err, 0);
    bytes = '{8'h77};
    send(bytes, 0);
    wait_idle();

    // write len 0: only the register word
    exp_addr.push_back(8'hA0);
    exp_wr.push_back(1);
    exp_word.push_back(8'h10);
    exp_go.push_back(0);
    exp_err.push_back(0);
    cmd(0, 7'h50, 8'h10, 0);
    wait_idle();

    // read len 0: immediate error, bus untouched
    en_seen = 0;
    exp_err.push_back(1);
    cmd(1, 7'h68, 8'h75, 0);
    chk("rd0_done", done, 1);
    chk("rd0_err", err, 1);
    wait_idle();
    chk("rd0_enable_never", en_seen, 0);

    // gapped LOAD, then a start while busy
    exp_addr.push_back(8'h54);
    exp_wr.push_back(1);
    exp_word = '{8'h33, 8'h01, 8'h80, 8'hFF};
    exp_go = '{1, 1, 1, 0};
    exp_err.push_back(0);
    cmd(0, 7'h2A, 8'h33, 3);
    bytes = '{8'h01, 8'h80, 8'hFF};
    send(bytes, 6);
    cmd(1, 7'h11, 8'h99, 0);
    chk("busy_start_ignored", busy, 1);
    wait_idle();

    // async reset during RUN
    exp_addr.push_back(8'hA0);
    exp_wr.push_back(1);
    exp_word = '{8'h20, 8'h11, 8'h22};
    exp_go = '{1, 1, 0};
    cmd(0, 7'h50, 8'h20, 2);
    bytes = '{8'h11, 8'h22};
    send(bytes, 0);
    for (int i = 0; i < 50 && ser_ready; i++) @(negedge clk);
    chk("run_entered", ser_ready, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 reset_state("mid");
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // clean read after reset
    exp_addr.push_back(8'hD1);
    exp_wr.push_back(0);
    exp_word.push_back(8'h05);
    exp_go = '{1, 0};
    rd_bytes.push_back(8'h9C);
    exp_rd.push_back(8'h9C);
    exp_err.push_back(0);
    cmd(1, 7'h68, 8'h05, 1);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_word", exp_word.size(), 0);
    chk("left_go", exp_go.size(), 0);
    chk("left_err", exp_err.size(), 0);
    chk("left_rst", exp_rst.size(), 0);
    chk("left_addr", exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
